// File: rtl/tcp_tx_session_sender.sv
// rtl/tcp_tx_session_sender.sv - TX session sender: metadata request, status wait, payload forwarding with TKEEP
// Optional feature macro: TX_RETRY_EN (refused requests back off and retry instead of draining the packet)
module tcp_tx_session_sender #(
    parameter int BACKOFF_CYCLES = 256
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic [544:0] pkt_rx_TDATA,
    input  logic         pkt_rx_TVALID,
    output logic         pkt_rx_TREADY,
    output logic [31:0]  m_axis_tx_metadata_TDATA,
    output logic         m_axis_tx_metadata_TVALID,
    input  logic         m_axis_tx_metadata_TREADY,
    input  logic [63:0]  s_axis_tx_status_TDATA,
    input  logic         s_axis_tx_status_TVALID,
    output logic         s_axis_tx_status_TREADY,
    output logic [511:0] m_axis_tx_data_TDATA,
    output logic [63:0]  m_axis_tx_data_TKEEP,
    output logic         m_axis_tx_data_TLAST,
    output logic         m_axis_tx_data_TVALID,
    input  logic         m_axis_tx_data_TREADY,
    output logic [31:0]  tx_pkt_count,
    output logic [15:0]  tx_err_count
);
    localparam int BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_STATUS,
        S_SEND,
        S_BACKOFF,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [15:0]   sess_q;
    logic [15:0]   len_q;
    logic [15:0]   bytes_left;
    logic [BW-1:0] backoff_cnt;
    logic          mismatch_seen;
    logic          err_inc;
    logic          pkt_inc;
    logic          len_err;

    logic [15:0] head_sess;
    logic [15:0] head_len;
    logic        in_last;
    logic        status_match;
    logic        status_err;
    logic        beat_acc;
    logic        send_beat;
    logic        unused_status_bits;

    assign head_sess    = pkt_rx_TDATA[528:513];
    assign head_len     = pkt_rx_TDATA[544:529];
    assign in_last      = pkt_rx_TDATA[512];
    assign status_match = s_axis_tx_status_TVALID && (s_axis_tx_status_TDATA[15:0] == sess_q);
    assign status_err   = (s_axis_tx_status_TDATA[63:62] != 2'b00);
    assign beat_acc     = pkt_rx_TVALID && pkt_rx_TREADY;
    assign send_beat    = (state == S_SEND) && beat_acc;

    // Echoed length and remaining space are informational only
    assign unused_status_bits = ^s_axis_tx_status_TDATA[61:16];

    assign s_axis_tx_status_TREADY  = 1'b1;
    assign m_axis_tx_metadata_TDATA = {len_q, sess_q};
    assign m_axis_tx_data_TDATA     = pkt_rx_TDATA[511:0];

    // Length disagreement is reported once per packet; forwarding continues regardless
    assign len_err = send_beat && !mismatch_seen &&
                     ((in_last && (bytes_left > 16'd64)) || (!in_last && (bytes_left == 16'd0)));

    always_comb begin
        state_next                = state;
        pkt_rx_TREADY             = 1'b0;
        m_axis_tx_metadata_TVALID = 1'b0;
        m_axis_tx_data_TVALID     = 1'b0;
        m_axis_tx_data_TKEEP      = 64'd0;
        m_axis_tx_data_TLAST      = 1'b0;
        err_inc                   = 1'b0;
        pkt_inc                   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pkt_rx_TVALID) begin
                    if (head_len == 16'd0) begin
                        state_next = S_DRAIN;
                        err_inc    = 1'b1;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                m_axis_tx_metadata_TVALID = 1'b1;
                if (m_axis_tx_metadata_TREADY) state_next = S_WAIT_STATUS;
            end
            S_WAIT_STATUS: begin
                if (status_match) begin
                    if (!status_err) begin
                        state_next = S_SEND;
                    end else begin
                        err_inc = 1'b1;
`ifdef TX_RETRY_EN
                        state_next = S_BACKOFF;
`else
                        state_next = S_DRAIN;
`endif
                    end
                end
            end
            S_SEND: begin
                m_axis_tx_data_TVALID = pkt_rx_TVALID;
                pkt_rx_TREADY         = m_axis_tx_data_TREADY;
                m_axis_tx_data_TLAST  = in_last;
                m_axis_tx_data_TKEEP  = (bytes_left >= 16'd64) ? {64{1'b1}}
                                        : ((64'd1 << bytes_left[5:0]) - 64'd1);
                err_inc = len_err;
                if (beat_acc && in_last) begin
                    pkt_inc    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_BACKOFF: begin
                if (backoff_cnt == '0) state_next = S_REQ;
            end
            S_DRAIN: begin
                pkt_rx_TREADY = 1'b1;
                if (pkt_rx_TVALID && in_last) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            sess_q        <= 16'd0;
            len_q         <= 16'd0;
            bytes_left    <= 16'd0;
            backoff_cnt   <= '0;
            mismatch_seen <= 1'b0;
            tx_pkt_count  <= 32'd0;
            tx_err_count  <= 16'd0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && pkt_rx_TVALID) begin
                sess_q        <= head_sess;
                len_q         <= head_len;
                bytes_left    <= head_len;
                mismatch_seen <= 1'b0;
            end
            if (send_beat) begin
                bytes_left <= (bytes_left >= 16'd64) ? (bytes_left - 16'd64) : 16'd0;
                if (len_err) mismatch_seen <= 1'b1;
            end
            // Loaded with N-1 so that exactly N cycles are spent in back-off
            if ((state == S_WAIT_STATUS) && (state_next == S_BACKOFF)) begin
                backoff_cnt <= BW'(BACKOFF_CYCLES - 1);
            end else if ((state == S_BACKOFF) && (backoff_cnt != '0)) begin
                backoff_cnt <= backoff_cnt - 1'b1;
            end
            if (pkt_inc) tx_pkt_count <= tx_pkt_count + 32'd1;
            if (err_inc && (tx_err_count != 16'hFFFF)) tx_err_count <= tx_err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_tcp_tx_session_sender.sv
// tb/tb_tcp_tx_session_sender.sv - randomized self-checking bench for tcp_tx_session_sender
module tb_tcp_tx_session_sender;
    localparam int BACKOFF = 8;
`ifdef TX_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [544:0] pkt_data;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [31:0]  meta_data;
    logic         meta_valid;
    logic         meta_ready;
    logic [63:0]  st_data;
    logic         st_valid;
    logic         st_ready;
    logic [511:0] d_data;
    logic [63:0]  d_keep;
    logic         d_last;
    logic         d_valid;
    logic         d_ready;
    logic [31:0]  pkt_cnt;
    logic [15:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_pkt = 0;
    int m_err = 0;
    bit allow_data = 1'b0;
    beat_t        exp_beats[$];
    logic [31:0]  exp_meta[$];
    logic [63:0]  obs_keep[$];
    logic [31:0]  obs_meta[$];
    logic [544:0] cur_beats[$];
    beat_t        cmp_b;

    tcp_tx_session_sender #(.BACKOFF_CYCLES(BACKOFF)) dut (
        .clk(clk),
        .aresetn(aresetn),
        .pkt_rx_TDATA(pkt_data),
        .pkt_rx_TVALID(pkt_valid),
        .pkt_rx_TREADY(pkt_ready),
        .m_axis_tx_metadata_TDATA(meta_data),
        .m_axis_tx_metadata_TVALID(meta_valid),
        .m_axis_tx_metadata_TREADY(meta_ready),
        .s_axis_tx_status_TDATA(st_data),
        .s_axis_tx_status_TVALID(st_valid),
        .s_axis_tx_status_TREADY(st_ready),
        .m_axis_tx_data_TDATA(d_data),
        .m_axis_tx_data_TKEEP(d_keep),
        .m_axis_tx_data_TLAST(d_last),
        .m_axis_tx_data_TVALID(d_valid),
        .m_axis_tx_data_TREADY(d_ready),
        .tx_pkt_count(pkt_cnt),
        .tx_err_count(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Random downstream back-pressure on both TX channels
    initial begin
        d_ready    = 1'b0;
        meta_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            d_ready    = 1'($urandom_range(0, 1));
            meta_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Compare process: every accepted metadata word and data beat against the model queues
    initial begin
        forever begin
            @(negedge clk);
            if (aresetn) begin
                if (meta_valid && meta_ready) begin
                    obs_meta.push_back(meta_data);
                    if (exp_meta.size() == 0) fail_now("unexpected_meta", $sformatf("got %0h expected none", meta_data));
                    else chk("meta", 64'(meta_data), 64'(exp_meta.pop_front()));
                end
                if (d_valid && d_ready) begin
                    obs_keep.push_back(d_keep);
                    if (!allow_data || exp_beats.size() == 0) begin
                        fail_now("unexpected_beat", $sformatf("got tvalid=1 keep=%0h expected none", d_keep));
                    end else begin
                        cmp_b = exp_beats.pop_front();
                        chk_data("beat_data", d_data, cmp_b.data);
                        chk("beat_keep", d_keep, cmp_b.keep);
                        chk("beat_last", 64'(d_last), 64'(cmp_b.last));
                    end
                end
            end
        end
    end

    task automatic wait_meta_hs(output bit ok, output int first_cyc);
        ok = 1'b0;
        first_cyc = -1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (meta_valid && first_cyc < 0) first_cyc = cyc;
            if (meta_valid && meta_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            fail_now("meta_timeout", "got no metadata handshake expected one");
        end
    endtask

    task automatic send_status(input logic [63:0] w, input bit ok_status, output int acc);
        bit found;
        found = 1'b0;
        acc = -1;
        st_data = w;
        st_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (st_ready) begin
                acc = cyc;
                if (ok_status) allow_data = 1'b1;
                found = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        if (!found) fail_now("status_timeout", "got status_TREADY=0 expected 1");
    endtask

    task automatic respond(input logic [15:0] s, input logic [15:0] len, input int n_mis,
                           input logic [15:0] mis_s, input int n_ref);
        bit ok;
        int fc;
        int acc;
        int dummy;
        acc = 0;
        for (int a = 0; a <= n_ref; a++) begin
            wait_meta_hs(ok, fc);
            if (!ok) return;
            if (a > 0) chk("backoff_gap", 64'(fc - acc), 64'(BACKOFF + 1));
            if (a == 0) begin
                for (int m = 0; m < n_mis; m++)
                    send_status({2'($urandom_range(1, 3)), 30'($urandom), len, mis_s}, 1'b0, dummy);
            end
            if (a < n_ref) begin
                send_status({2'($urandom_range(1, 3)), 30'($urandom), len, s}, 1'b0, acc);
                if (!RETRY) return;
            end else begin
                send_status({2'b00, 30'($urandom), len, s}, 1'b1, acc);
            end
        end
    endtask

    task automatic drive_pkt(input int n);
        bit found;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                pkt_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            pkt_data = cur_beats[i];
            pkt_valid = 1'b1;
            found = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                @(negedge clk);
                if (pkt_ready) begin
                    found = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (!found) begin
                fail_now("beat_timeout", $sformatf("got no pkt_rx handshake for beat %0d expected one", i));
                pkt_valid = 1'b0;
                return;
            end
        end
        pkt_valid = 1'b0;
    endtask

    // Builds the packet, derives every expected output from the packet rules, then runs it
    task automatic build_pkt(input logic [15:0] s, input logic [15:0] len, input int nb,
                             input int n_ref, output bit sent);
        logic [511:0] pl;
        beat_t b;
        int rem;
        bit bad;
        cur_beats.delete();
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 16; k++) pl[k*32 +: 32] = $urandom;
            if (i == 0) cur_beats.push_back({len, s, (i == nb - 1), pl});
            else cur_beats.push_back({16'($urandom), 16'($urandom), (i == nb - 1), pl});
        end
        sent = 1'b0;
        if (len == 16'd0) begin
            m_err++;
        end else begin
            for (int a = 0; a < (RETRY ? n_ref + 1 : 1); a++) exp_meta.push_back({len, s});
            if (n_ref > 0) m_err += RETRY ? n_ref : 1;
            sent = RETRY || (n_ref == 0);
        end
        if (sent) begin
            bad = 1'b0;
            for (int i = 0; i < nb; i++) begin
                rem = int'(len) - 64 * i;
                if (rem < 0) rem = 0;
                b.data = cur_beats[i][511:0];
                b.keep = (rem >= 64) ? {64{1'b1}} : ((64'd1 << rem) - 64'd1);
                b.last = (i == nb - 1);
                exp_beats.push_back(b);
                if (i == nb - 1 && rem > 64) bad = 1'b1;
                if (i != nb - 1 && rem == 0) bad = 1'b1;
            end
            m_pkt++;
            if (bad) m_err++;
        end
        if (m_err > 65535) m_err = 65535;
        allow_data = 1'b0;
    endtask

    task automatic run_pkt(input logic [15:0] s, input logic [15:0] len, input int nb,
                           input int n_mis, input logic [15:0] mis_s, input int n_ref);
        bit sent;
        build_pkt(s, len, nb, n_ref, sent);
        fork
            drive_pkt(nb);
            begin
                if (len != 16'd0) respond(s, len, n_mis, mis_s, n_ref);
            end
        join
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pkt_count", 64'(pkt_cnt), 64'(m_pkt));
        chk("err_count", 64'(err_cnt), 64'(m_err));
        chk("beats_pending", 64'(exp_beats.size()), 64'd0);
        chk("meta_pending", 64'(exp_meta.size()), 64'd0);
        exp_beats.delete();
        exp_meta.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_data_valid"}, 64'(d_valid), 64'd0);
        chk({tag, "_pkt_ready"}, 64'(pkt_ready), 64'd0);
        chk({tag, "_keep"}, d_keep, 64'd0);
        chk({tag, "_last"}, 64'(d_last), 64'd0);
        chk({tag, "_meta_valid"}, 64'(meta_valid), 64'd0);
        chk({tag, "_pkt_count"}, 64'(pkt_cnt), 64'd0);
        chk({tag, "_err_count"}, 64'(err_cnt), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic [15:0] len;
        int nb;
        int n_ref;
        bit sent;
        aresetn = 1'b0;
        pkt_valid = 1'b0;
        pkt_data = '0;
        st_valid = 1'b0;
        st_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;
        aresetn = 1'b1;

        obs_keep.delete();
        obs_meta.delete();
        run_pkt(16'h0005, 16'd40, 1, 0, 16'h0, 0);
        chk("t1_meta_count", 64'(obs_meta.size()), 64'd1);
        if (obs_meta.size() >= 1) chk("t1_meta", 64'(obs_meta[0]), 64'h0028_0005);
        chk("t1_beats", 64'(obs_keep.size()), 64'd1);
        if (obs_keep.size() >= 1) chk("t1_keep", obs_keep[0], 64'h0000_00FF_FFFF_FFFF);
        chk("t1_pkt", 64'(pkt_cnt), 64'd1);

        obs_keep.delete();
        run_pkt(16'h0011, 16'd130, 3, 0, 16'h0, 0);
        chk("t2_beats", 64'(obs_keep.size()), 64'd3);
        if (obs_keep.size() >= 3) begin
            chk("t2_keep0", obs_keep[0], 64'hFFFF_FFFF_FFFF_FFFF);
            chk("t2_keep1", obs_keep[1], 64'hFFFF_FFFF_FFFF_FFFF);
            chk("t2_keep2", obs_keep[2], 64'h3);
        end
        chk("t2_pkt", 64'(pkt_cnt), 64'd2);

        run_pkt(16'h0005, 16'd64, 1, 1, 16'h0009, 0);
        chk("t3_err", 64'(err_cnt), 64'd0);
        chk("t3_pkt", 64'(pkt_cnt), 64'd3);

        obs_keep.delete();
        run_pkt(16'h0007, 16'd200, 4, 0, 16'h0, 1);
        chk("t4_err", 64'(err_cnt), 64'd1);
        chk("t4_pkt", 64'(pkt_cnt), RETRY ? 64'd4 : 64'd3);
        chk("t4_beats", 64'(obs_keep.size()), RETRY ? 64'd4 : 64'd0);

        run_pkt(16'h0021, 16'd0, 2, 0, 16'h0, 0);
        chk("t5_err", 64'(err_cnt), 64'd2);

        for (int p = 0; p < 40; p++) begin
            s = 16'($urandom);
            len = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 400));
            nb = (len == 16'd0) ? int'($urandom_range(1, 3)) : (int'(len) + 63) / 64;
            case ($urandom_range(0, 5))
                0: nb = nb + 1;
                1: if (nb > 1) nb = nb - 1;
                default: ;
            endcase
            n_ref = RETRY ? int'($urandom_range(0, 2)) : (($urandom_range(0, 3) == 0) ? 1 : 0);
            run_pkt(s, len, nb, int'($urandom_range(0, 1)), s ^ (16'h1 << $urandom_range(0, 15)), n_ref);
        end

        // Reset in the middle of a 5-beat packet, after two beats have gone out
        build_pkt(16'h0033, 16'd320, 5, 0, sent);
        fork
            drive_pkt(2);
            respond(16'h0033, 16'd320, 0, 16'h0, 0);
        join
        pkt_data = cur_beats[2];
        pkt_valid = 1'b1;
        aresetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("midreset");
        exp_beats.delete();
        exp_meta.delete();
        pkt_valid = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        m_pkt = 0;
        m_err = 0;
        run_pkt(16'h0044, 16'd100, 2, 0, 16'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
